// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns program counter evolution and fetches one
// instruction at a time over a request/ready handshake to instruction memory.
module fetch_unit #(
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          INSTR_W  = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   cur_pc,
    output logic [ADDR_W-1:0]   n_pc,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic                imem_req,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                instr_valid,
    input  logic                instr_accept,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_target,
    input  logic                halt,
    output logic                halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [INSTR_W-1:0]   instr_reg, instr_next;
    logic [ADDR_W-1:0]    instr_pc_reg, instr_pc_next;
    logic                 valid_reg, valid_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
            valid_reg    <= valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        valid_next    = valid_reg;
        n_pc          = cur_pc;

        if (state_reg == HALT) begin
            valid_next = 1'b0;
        end else if (halt) begin
            state_next = HALT;
            valid_next = 1'b0;
        end else if (redirect) begin
            // Any data returning this cycle is dropped; old instr/instr_pc stay.
            n_pc       = redirect_target;
            valid_next = 1'b0;
            state_next = FETCH;
        end else begin
            case (state_reg)
                IDLE: begin
                    n_pc       = RESET_PC;
                    state_next = FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_next    = imem_data;
                        instr_pc_next = cur_pc;
                        valid_next    = 1'b1;
                        n_pc          = cur_pc + ADDR_W'(1);
                        state_next    = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_accept) begin
                        valid_next = 1'b0;
                        state_next = FETCH;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // The program counter has no reset of its own, so feed it the vector
        // for as long as reset is asserted.
        if (!rst_n) begin
            n_pc = RESET_PC;
        end
    end

    assign imem_addr   = cur_pc;
    assign imem_req    = (state_reg == FETCH);
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = valid_reg;
    assign halted      = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed boot/fetch/redirect/halt/reset sequence plus a
// randomized phase, checked against a behavioural model of PC and instruction flow.
module tb_fetch_unit;

    localparam logic [7:0] RST_PC = 8'h10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cur_pc;
    logic [7:0] n_pc;
    logic [7:0] imem_addr;
    logic       imem_req;
    logic       imem_ready = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_accept = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_target = 8'h00;
    logic       halt = 1'b0;
    logic       halted;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: booting / halted flags, a held instruction, and the PC.
    bit m_boot, m_halted, m_valid;
    int m_pc, m_instr, m_ipc;

    fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .cur_pc(cur_pc), .n_pc(n_pc),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ready(imem_ready),
        .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_accept(instr_accept),
        .redirect(redirect), .redirect_target(redirect_target),
        .halt(halt), .halted(halted)
    );

    always #5 clk = ~clk;

    // The program counter itself: no enable, no reset.
    always @(posedge clk) cur_pc <= n_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_halted = 0; m_valid = 0;
        m_pc = RST_PC; m_instr = 0; m_ipc = 0;
    endtask

    // Inputs are already driven (just after a falling edge); check, advance model, move one cycle.
    task automatic step();
        bit ereq;
        int enpc;
        #1;
        ereq = !m_boot && !m_halted && !m_valid;
        if (m_halted || halt)   enpc = m_pc;
        else if (redirect)      enpc = redirect_target;
        else if (m_boot)        enpc = RST_PC;
        else if (ereq && imem_ready) enpc = (m_pc + 1) % 256;
        else                    enpc = m_pc;

        chk("imem_req", imem_req, ereq);
        chk("imem_addr", imem_addr, m_pc[7:0]);
        chk("n_pc", n_pc, enpc[7:0]);
        chk("instr_valid", instr_valid, m_valid);
        chk("instr", instr, m_instr[7:0]);
        chk("instr_pc", instr_pc, m_ipc[7:0]);
        chk("halted", halted, m_halted);
        $display("t=%0t pc=%02h req=%0b rdy=%0b acc=%0b rdr=%0b halt=%0b n_pc=%02h valid=%0b instr=%02h@%02h",
                 $time, cur_pc, imem_req, imem_ready, instr_accept, redirect, halt,
                 n_pc, instr_valid, instr, instr_pc);

        if (!m_halted) begin
            if (halt) begin
                m_halted = 1; m_valid = 0; m_boot = 0;
            end else if (redirect) begin
                m_valid = 0; m_boot = 0;
            end else if (m_boot) begin
                m_boot = 0;
            end else if (ereq && imem_ready) begin
                m_valid = 1; m_instr = imem_data; m_ipc = m_pc;
            end else if (m_valid && instr_accept) begin
                m_valid = 0;
            end
        end
        m_pc = enpc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit rdy, input logic [7:0] dat, input bit acc,
                         input bit rdr, input logic [7:0] tgt, input bit hlt);
        imem_ready = rdy; imem_data = dat; instr_accept = acc;
        redirect = rdr; redirect_target = tgt; halt = hlt;
        step();
    endtask

    initial begin
        // Reset held for three edges: PC must be loaded with the vector throughout.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_n_pc", n_pc, RST_PC);
            chk("rst_req", imem_req, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_cur_pc", cur_pc, RST_PC);
        rst_n = 1'b1;
        model_reset();

        // Boot, then A1 (no wait), A2 (2 waits), A3 (1 wait), immediate accept.
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        drive(1, 8'hA1, 0, 0, 8'h00, 0);
        chk("a1_instr", instr, 8'hA1);
        chk("a1_pc", instr_pc, 8'h10);
        drive(0, 8'h00, 1, 0, 8'h00, 0);
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        drive(1, 8'hA2, 0, 0, 8'h00, 0);
        chk("a2_pc", instr_pc, 8'h11);
        drive(0, 8'h00, 1, 0, 8'h00, 0);
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        drive(1, 8'hA3, 0, 0, 8'h00, 0);
        chk("a3_instr", instr, 8'hA3);
        chk("a3_pc", instr_pc, 8'h12);

        // Backpressure: four cycles without accept, then accept.
        for (int i = 0; i < 4; i++) drive(0, 8'h00, 0, 0, 8'h00, 0);
        drive(0, 8'h00, 1, 0, 8'h00, 0);
        chk("bp_req_after_accept", imem_req, 1'b1);

        // Redirect together with returning data: data is discarded.
        drive(1, 8'hEE, 0, 1, 8'h40, 0);
        chk("rdr_discard", instr_valid, 1'b0);
        chk("rdr_addr", imem_addr, 8'h40);

        // Wrap-around from 8'hFF.
        drive(0, 8'h00, 0, 1, 8'hFF, 0);
        drive(1, 8'h5A, 0, 0, 8'h00, 0);
        chk("wrap_ipc", instr_pc, 8'hFF);
        chk("wrap_pc", cur_pc, 8'h00);
        drive(0, 8'h00, 1, 0, 8'h00, 0);

        // Randomized phase.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0), 8'($urandom), 0);
        end

        // Halt with simultaneous redirect, then random inputs are ignored.
        drive(1, 8'h77, 1, 1, 8'h99, 1);
        chk("halt_halted", halted, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        end

        // Asynchronous reset pulse between edges.
        imem_ready = 0; instr_accept = 0; redirect = 0; halt = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_halted", halted, 1'b0);
        chk("async_valid", instr_valid, 1'b0);
        chk("async_req", imem_req, 1'b0);
        chk("async_n_pc", n_pc, RST_PC);
        chk("async_instr", instr, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        chk("reboot_addr", imem_addr, RST_PC);
        drive(1, 8'hC3, 0, 0, 8'h00, 0);
        drive(0, 8'h00, 1, 0, 8'h00, 0);
        drive(0, 8'h00, 0, 0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
